layer_sequencer: RTL

- Sequences a chain of NUM_LAYERS dense layers through one inference.
- Per layer: pulses the layer's start, waits for its done rising edge, then pulses a capture enable for the inter-layer register.
- Reports completion, total latency and per-layer timeout errors.
- Sits between the top-level inference request and the dense layer instances; owns no datapath.

---
 rtl/layer_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer
// Runs one inference through a chain of NUM_LAYERS dense layers. For each layer
// it pulses that layer's start, waits for a rising edge on its done level, and
// then pulses the capture enable of the layer's output register. It also reports
// completion, total latency and per-layer timeouts. This block has no datapath.
//
// Ports
//   i_clk           clock; all state changes on the rising edge
//   i_rst           asynchronous, active-high reset (returns to IDLE)
//   i_start         request one inference (accepted in IDLE or ERROR)
//   i_abort         cancel the current run (back to IDLE)
//   i_layer_done    per-layer completion levels
//   o_layer_start   one-hot, one-cycle start pulse for the current layer
//   o_capture       one-hot, one-cycle load enable for the current layer's output
//   o_current_layer index of the layer in progress (held while in ERROR)
//   o_busy          high in LAUNCH, WAIT, CAPTURE and FINISH
//   o_done          one-cycle pulse at the end of a successful run
//   o_error         high while in ERROR (layer timeout)
//   o_cycle_count   latency of the last or current run, saturating
module layer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CL_W          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [NUM_LAYERS-1:0] i_layer_done,
    output logic [NUM_LAYERS-1:0] o_layer_start,
    output logic [NUM_LAYERS-1:0] o_capture,
    output logic [CL_W-1:0]       o_current_layer,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [31:0]           o_cycle_count
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [CL_W-1:0]       r_cur_layer;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_done_prev;
    logic [31:0]           r_cycle_count;
    logic [NUM_LAYERS-1:0] r_layer_start;
    logic [NUM_LAYERS-1:0] r_capture;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    function automatic logic [NUM_LAYERS-1:0] f_onehot(input logic [CL_W-1:0] idx);
        logic [NUM_LAYERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Outputs are registered alongside the state: each pulse is set on the
    // transition into the state that owns it and cleared by the default below.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cur_layer   <= '0;
            r_wait_cnt    <= '0;
            r_done_prev   <= 1'b0;
            r_cycle_count <= '0;
            r_layer_start <= '0;
            r_capture     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            // Edge detector for the selected layer's done level. Because it
            // samples during LAUNCH, a level already high at launch is stale.
            r_done_prev   <= i_layer_done[r_cur_layer];
            r_layer_start <= '0;
            r_capture     <= '0;
            r_done        <= 1'b0;

            if (i_abort && r_state != S_IDLE) begin
                // Abort wins over everything; the latency counter is frozen.
                r_state     <= S_IDLE;
                r_cur_layer <= '0;
                r_busy      <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                if ((r_state == S_LAUNCH || r_state == S_WAIT || r_state == S_CAPTURE)
                    && r_cycle_count != '1)
                    r_cycle_count <= r_cycle_count + 32'd1;

                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (i_start && !i_abort) begin
                            r_state       <= S_LAUNCH;
                            r_cur_layer   <= '0;
                            r_cycle_count <= '0;
                            r_error       <= 1'b0;
                            r_busy        <= 1'b1;
                            r_layer_start <= f_onehot('0);
                        end
                    end
                    S_LAUNCH: begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        // A done edge beats the timeout in the same cycle.
                        if (i_layer_done[r_cur_layer] && !r_done_prev) begin
                            r_state   <= S_CAPTURE;
                            r_capture <= f_onehot(r_cur_layer);
                        end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        if (r_cur_layer == CL_W'(NUM_LAYERS - 1)) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_LAUNCH;
                            r_cur_layer   <= r_cur_layer + CL_W'(1);
                            r_layer_start <= f_onehot(r_cur_layer + CL_W'(1));
                        end
                    end
                    S_FINISH: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cur_layer <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_layer_start   = r_layer_start;
    assign o_capture       = r_capture;
    assign o_current_layer = r_cur_layer;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;
    assign o_cycle_count   = r_cycle_count;

endmodule
